// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: round-robin arbitration of channel samples onto one FIFO write port,
// gated by an arm/trigger/post-count window. Define ADC_CAPTURE_CHTAG_EN to tag words with the channel index.
module adc_capture_ctrl #(
    parameter int NUM_CH       = 4,
    parameter int SAMPLE_WIDTH = 14,
    parameter int FIFO_WIDTH   = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           arm,
    input  logic                           abort,
    input  logic                           trig,
    input  logic [CNT_WIDTH-1:0]           post_count,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]              ch_ack,
    input  logic                           fifo_full,
    output logic                           fifo_we,
    output logic [FIFO_WIDTH-1:0]          fifo_d,
    output logic [1:0]                     state,
    output logic                           done,
    output logic [7:0]                     drop_cnt
);

    localparam int RR_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    state_t                  r_state;
    logic [RR_W-1:0]         r_rr;
    logic [CNT_WIDTH-1:0]    r_post_len;
    logic [CNT_WIDTH-1:0]    r_cap_cnt;
    logic [7:0]              r_drop_cnt;
    logic                    r_done;
    logic                    r_fifo_we;
    logic [FIFO_WIDTH-1:0]   r_fifo_d;

    logic [NUM_CH-1:0]       w_ack;
    logic [RR_W-1:0]         w_gnt_idx;
    logic                    w_grant;
    logic [SAMPLE_WIDTH-1:0] w_sample;
    logic [FIFO_WIDTH-1:0]   w_word;
    logic [CNT_WIDTH-1:0]    w_cap_next;
    logic [RR_W-1:0]         w_rr_next;
    int                      w_k;

    // Scan from the lowest-priority offset down so the channel nearest rr is the last one kept.
    always_comb begin
        w_ack     = '0;
        w_gnt_idx = '0;
        w_k       = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_k = int'(r_rr) + i;
            if (w_k >= NUM_CH) begin
                w_k = w_k - NUM_CH;
            end
            if (ch_valid[w_k]) begin
                w_ack      = '0;
                w_ack[w_k] = 1'b1;
                w_gnt_idx  = RR_W'(w_k);
            end
        end
    end

    assign w_grant    = |ch_valid;
    assign w_sample   = ch_data[int'(w_gnt_idx)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign w_cap_next = r_cap_cnt + CNT_WIDTH'(1);
    assign w_rr_next  = (w_gnt_idx == RR_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_word                   = '0;
        w_word[SAMPLE_WIDTH-1:0] = w_sample;
`ifdef ADC_CAPTURE_CHTAG_EN
        w_word[FIFO_WIDTH-1 -: 3] = 3'(w_gnt_idx);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rr       <= '0;
            r_post_len <= '0;
            r_cap_cnt  <= '0;
            r_drop_cnt <= '0;
            r_done     <= 1'b0;
            r_fifo_we  <= 1'b0;
            r_fifo_d   <= '0;
        end else begin
            r_fifo_we <= 1'b0;
            if (w_grant) begin
                r_rr <= w_rr_next;
            end

            // The data path acts on the current state; a same-cycle abort only redirects the FSM.
            if (w_grant && r_state == S_CAPTURE) begin
                if (!fifo_full) begin
                    r_fifo_we <= 1'b1;
                    r_fifo_d  <= w_word;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
                r_cap_cnt <= w_cap_next;
            end

            if (abort) begin
                r_state <= S_IDLE;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            r_state    <= S_ARMED;
                            r_done     <= 1'b0;
                            r_post_len <= post_count;
                            r_cap_cnt  <= '0;
                            r_drop_cnt <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (trig) begin
                            if (r_post_len == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_CAPTURE;
                            end
                        end
                    end
                    S_CAPTURE: begin
                        if (w_grant && w_cap_next == r_post_len) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ch_ack   = w_ack;
    assign fifo_we  = r_fifo_we;
    assign fifo_d   = r_fifo_d;
    assign state    = r_state;
    assign done     = r_done;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: expected FIFO words queued at grant time and
// checked by a write monitor on the falling edge.
module tb_adc_capture_ctrl;

    localparam int NCH = 4;
    localparam int SW  = 14;
`ifdef ADC_CAPTURE_CHTAG_EN
    localparam int FW  = 17;
`else
    localparam int FW  = 16;
`endif
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              arm;
    logic              abort;
    logic              trig;
    logic [CW-1:0]     post_count;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*SW-1:0] ch_data;
    logic [NCH-1:0]    ch_ack;
    logic              fifo_full;
    logic              fifo_we;
    logic [FW-1:0]     fifo_d;
    logic [1:0]        state;
    logic              done;
    logic [7:0]        drop_cnt;

    logic [FW-1:0] exp_q[$];
    int n_cmp    = 0;
    int n_mis    = 0;
    int n_writes = 0;
    int exp_rr   = 0;
    int w0       = 0;
    logic [SW-1:0] smp;

    adc_capture_ctrl #(
        .NUM_CH(NCH), .SAMPLE_WIDTH(SW), .FIFO_WIDTH(FW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .trig(trig),
        .post_count(post_count), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ack(ch_ack), .fifo_full(fifo_full), .fifo_we(fifo_we), .fifo_d(fifo_d),
        .state(state), .done(done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_word(input int ch, input logic [SW-1:0] s);
        logic [FW-1:0] w;
        w = '0;
        w[SW-1:0] = s;
`ifdef ADC_CAPTURE_CHTAG_EN
        w[FW-1 -: 3] = 3'(ch);
`endif
        return w;
    endfunction

    task automatic set_ch(input int k, input logic [SW-1:0] v);
        ch_data[k*SW +: SW] = v;
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (fifo_we === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0)
                check("write_without_expect", 32'(fifo_we), 32'd0);
            else
                check("fifo_d", 32'(fifo_d), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        reset_n = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        post_count = '0; ch_valid = '0; ch_data = '0; fifo_full = 1'b0;
        repeat (3) step();
        #2;
        check("rst_ack", 32'(ch_ack), 32'd0);
        check("rst_we", 32'(fifo_we), 32'd0);
        check("rst_d", 32'(fifo_d), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // Round-robin with all channels requesting in IDLE: nothing written.
        step();
        reset_n = 1'b1;
        ch_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #2;
            check("rr_ack", 32'(ch_ack), 32'(1 << (i % 4)));
            check("idle_state", 32'(state), 32'd0);
            step();
        end
        ch_valid = '0;
        check("idle_no_write", 32'(n_writes), 32'd0);

        // post_count=5, channel 2 streams 0x0123.
        arm = 1'b1; post_count = 16'd5;
        step();
        arm = 1'b0; trig = 1'b1;
        #2 check("armed_state", 32'(state), 32'd1);
        step();
        trig = 1'b0;
        set_ch(2, 14'h0123);
        ch_valid = 4'b0100;
        w0 = n_writes;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("cap_state", 32'(state), 32'd2);
            check("cap_ack", 32'(ch_ack), 32'h4);
            exp_q.push_back(exp_word(2, 14'h0123));
            step();
        end
        #2;
        check("t2_done", 32'(done), 32'd1);
        check("t2_state", 32'(state), 32'd3);
        step();
        ch_valid = '0;
        exp_rr = 3;
        step();
        check("t2_writes", 32'(n_writes - w0), 32'd5);

        // post_count=10, all channels requesting, FIFO full for grants 2..4.
        arm = 1'b1; post_count = 16'd10;
        step();
        arm = 1'b0; trig = 1'b1;
        step();
        trig = 1'b0;
        w0 = n_writes;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < NCH; k++) set_ch(k, 14'h2000 | 14'(i << 4) | 14'(k));
            ch_valid = 4'b1111;
            fifo_full = (i >= 2 && i <= 4);
            #2;
            check("t3_ack", 32'(ch_ack), 32'(1 << exp_rr));
            smp = 14'h2000 | 14'(i << 4) | 14'(exp_rr);
            if (!fifo_full) exp_q.push_back(exp_word(exp_rr, smp));
            exp_rr = (exp_rr + 1) % NCH;
            step();
        end
        ch_valid = '0; fifo_full = 1'b0;
        #2;
        check("t3_state", 32'(state), 32'd3);
        check("t3_done", 32'(done), 32'd1);
        check("t3_drop", 32'(drop_cnt), 32'd3);
        step();
        step();
        check("t3_writes", 32'(n_writes - w0), 32'd7);

        // Drop counter saturation: 300 grants into a full FIFO, post_count=400.
        arm = 1'b1; post_count = 16'd400;
        step();
        arm = 1'b0; trig = 1'b1;
        #2 check("t4_drop_clr", 32'(drop_cnt), 32'd0);
        step();
        trig = 1'b0; fifo_full = 1'b1; ch_valid = 4'b0001;
        set_ch(0, 14'h1555);
        for (int i = 0; i < 300; i++) step();
        ch_valid = '0; fifo_full = 1'b0;
        step();
        check("t4_drop_sat", 32'(drop_cnt), 32'd255);
        check("t4_state", 32'(state), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #2 check("t4_abort_state", 32'(state), 32'd0);

        // post_count=0: trigger goes straight to DONE; samples throughout are discarded.
        w0 = n_writes;
        ch_valid = 4'b0010;
        arm = 1'b1; post_count = 16'd0;
        step();
        arm = 1'b0;
        #2;
        check("t5_armed", 32'(state), 32'd1);
        check("t5_drop_clr", 32'(drop_cnt), 32'd0);
        trig = 1'b1;
        step();
        trig = 1'b0;
        #2;
        check("t5_done_state", 32'(state), 32'd3);
        check("t5_done", 32'(done), 32'd1);
        arm = 1'b1; post_count = 16'd8;
        step();
        arm = 1'b0; ch_valid = '0;
        #2;
        check("t5_rearm", 32'(state), 32'd1);
        check("t5_rearm_drop", 32'(drop_cnt), 32'd0);
        check("t5_rearm_done", 32'(done), 32'd0);
        step();
        check("t5_writes", 32'(n_writes - w0), 32'd0);

        // Abort after 3 of 8 written; arm during capture is ignored.
        trig = 1'b1;
        step();
        trig = 1'b0;
        w0 = n_writes;
        ch_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            set_ch(3, 14'h0AB0 + 14'(i));
            arm = (i == 1);
            post_count = 16'd1;
            exp_q.push_back(exp_word(3, 14'h0AB0 + 14'(i)));
            step();
        end
        arm = 1'b0; ch_valid = '0;
        #2 check("t6_still_cap", 32'(state), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #2 check("t6_idle", 32'(state), 32'd0);
        ch_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #2 check("t6_idle_ack", 32'(ch_ack), 32'h8);
            step();
        end
        ch_valid = '0;
        step();
        check("t6_writes", 32'(n_writes - w0), 32'd3);

        // Reset mid-capture: first grant written, second cancelled by reset.
        arm = 1'b1; post_count = 16'd8;
        step();
        arm = 1'b0; trig = 1'b1;
        step();
        trig = 1'b0;
        set_ch(1, 14'h0155);
        ch_valid = 4'b0010;
        exp_q.push_back(exp_word(1, 14'h0155));
        step();
        reset_n = 1'b0;
        step();
        ch_valid = '0;
        #2;
        check("t7_we", 32'(fifo_we), 32'd0);
        check("t7_d", 32'(fifo_d), 32'd0);
        check("t7_state", 32'(state), 32'd0);
        check("t7_done", 32'(done), 32'd0);
        check("t7_drop", 32'(drop_cnt), 32'd0);
        check("t7_ack", 32'(ch_ack), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        ch_valid = 4'b1111;
        #2 check("t7_rr_reset", 32'(ch_ack), 32'd1);
        step();
        ch_valid = '0;
        step();
        step();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture sequencer and write-side arbiter for the ADC sample FIFO. It accepts samples from up to NUM_CH ADC channel front-ends, shares the single FIFO write port between them round-robin, and gates writes through an arm/trigger/post-count capture window. It sits between the channel front-ends and the FIFO's `we`/`d`/`full` pins. It reports capture state, completion and dropped-sample count to the launch control logic.

## Interface
- NUM_CH, 4: number of channel requesters (2..8).
- SAMPLE_WIDTH, 14: bits per channel sample.
- FIFO_WIDTH, 16: FIFO word width; must be ≥ SAMPLE_WIDTH + 3 when tagging is enabled, ≥ SAMPLE_WIDTH otherwise.
- CNT_WIDTH, 16: width of post-trigger sample count.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- arm  in  1  start a capture (IDLE/DONE only).
- abort  in  1  return to IDLE from any state.
- trig  in  1  trigger, level-sampled in ARMED.
- post_count  in  CNT_WIDTH  samples to capture after trigger; latched on arm.
- ch_valid  in  NUM_CH  per-channel sample available; held until acked.
- ch_data  in  NUM_CH*SAMPLE_WIDTH  channel k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- ch_ack  out  NUM_CH  one-hot combinational grant; sample consumed this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_we  out  1  FIFO write enable (registered).
- fifo_d  out  FIFO_WIDTH  FIFO write data (registered).
- state  out  2  00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE.
- done  out  1  high while in DONE.
- drop_cnt  out  8  saturating count of samples dropped on full this capture.

## Operation
- Arbiter: a round-robin pointer `rr` names the highest-priority channel. The grant goes to the first asserted ch_valid at or after `rr`, wrapping. Exactly one ch_ack per cycle when any valid is asserted, in every state including IDLE. After a grant to channel k, `rr` ← (k+1) mod NUM_CH. `rr` is unchanged with no grant.
- Samples are always acked. Whether an acked sample is written depends on state:
  - IDLE, ARMED, DONE: discarded.
  - CAPTURE: written if fifo_full=0; otherwise dropped and drop_cnt incremented, saturating at 255.
- FSM:
  - IDLE→ARMED on arm. Latch post_count into `post_len`, clear `cap_cnt` and drop_cnt.
  - ARMED→CAPTURE on trig.
  - If `post_len`=0, ARMED→DONE on trig instead.
  - CAPTURE: each grant (written or dropped) increments `cap_cnt`. On the grant where `cap_cnt`+1 == `post_len`, go to DONE.
  - DONE→ARMED on arm, re-latching and clearing as from IDLE.
  - abort from any state→IDLE. abort has priority over arm and trig.
  - arm in ARMED or CAPTURE is ignored.
- `cap_cnt` is CNT_WIDTH bits and never wraps: the terminal compare fires first.
- fifo_d: the sample is zero-extended to FIFO_WIDTH. When tagging is enabled, the channel index goes in bits [FIFO_WIDTH-1 -: 3].

## Timing
- Reset values: ch_ack=0 (with all valid low), fifo_we=0, fifo_d=0, state=IDLE, done=0, drop_cnt=0, rr=0, cap_cnt=0, post_len=0.
- ch_ack is combinational from ch_valid, `rr` and nothing else. Reset does not force it low, so channels must hold ch_valid low during reset.
- Write latency: sample acked in cycle N → fifo_we=1 with fifo_d in cycle N+1. Throughput is 1 sample/cycle.
- The full decision uses fifo_full in the grant cycle. The FIFO full threshold (depth ≥ words−3) absorbs the 1-cycle write latency.
- State changes take effect the cycle after the causing input:
  - Samples granted in the trig cycle are discarded.
  - The terminal grant is written, or dropped if full.
  - Samples in the first DONE cycle are discarded.
- abort in cycle N: state=IDLE at N+1. A write registered at N still appears at N+1. No writes occur after that.
- reset_n low mid-capture: all state returns to reset values at the next edge. A pending fifo_we is cancelled.

## Configuration
- ADC_CAPTURE_CHTAG_EN defined: fifo_d[FIFO_WIDTH-1 -: 3] carries the granted channel index, so the reader can demultiplex.
- ADC_CAPTURE_CHTAG_EN undefined: no tag; fifo_d is the zero-extended raw sample.
- Arbitration and sequencing are identical in both builds.

## Test plan
- Reset, then ch_valid=4'b1111 held for 8 cycles: ch_ack sequence is 0001,0010,0100,1000 repeating; fifo_we stays 0; state=00.
- arm with post_count=5, trig, channel 2 streaming 0x0123: exactly 5 writes of 0x0123 (tag 2 when enabled). done=1 the cycle after the 5th ack.
- In CAPTURE with fifo_full forced 1 for 3 grants, post_count=10: 7 writes, drop_cnt=3, DONE after the 10th grant.
- Hold fifo_full=1 for 300 grants with post_count=400: drop_cnt saturates at 255.
- post_count=0, arm, trig: ARMED→DONE with zero writes. Then arm again: state=ARMED and drop_cnt=0.
- abort mid-capture (3 of 8 written): state=IDLE next cycle, at most one trailing write, no further writes. Repeat with reset_n=0 mid-capture: all outputs return to reset values.
